cmul_arbiter: RTL and testbench
===============================

# cmul_arbiter

Round-robin arbiter that shares one external pipelined complex multiplier between two requesters in the MOSSE frequency-domain datapath (e.g. correlation path F·conj(H) and filter-update path G·conj(F)). Each request carries operands A and B plus a per-beat conjugate flag; the block conjugates B when requested, issues the pair to the multiplier, tracks ownership of every in-flight product with a LAT-deep tag pipeline, and returns each product to the requester that issued it. Complex words are packed {imag, real}, each component a signed two's-complement WIDTH-bit field.

## Interface

- WIDTH, 32, bits per real/imag component of operands
- LAT, 4, fixed multiplier latency in cycles from m_valid to matching m_p (LAT >= 1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s0_valid / s1_valid  in  1  request valid, requester 0/1
- s0_ready / s1_ready  out  1  request accepted this cycle when valid&ready
- s0_a / s1_a  in  2*WIDTH  operand A {imag, real}
- s0_b / s1_b  in  2*WIDTH  operand B {imag, real}
- s0_conj / s1_conj  in  1  1: use conj(B)
- m_valid  out  1  operand pair valid to multiplier (multiplier never stalls)
- m_a, m_b  out  2*WIDTH  operands to multiplier (m_b already conjugated)
- m_p  in  4*WIDTH  product {imag, real}, 2*WIDTH each, valid LAT cycles after m_valid
- r0_valid / r1_valid  out  1  one-cycle result strobe, requester 0/1 (no backpressure)
- r0_data / r1_data  out  4*WIDTH  product returned to requester 0/1
- idle  out  1  no issue register or tag pipeline entry valid

## Operation

- Priority pointer ptr (1 bit), reset 0.
- s0_ready = !rst & (ptr==0 | !s1_valid); s1_ready = !rst & (ptr==1 | !s0_valid). Ready depends only on the other requester's valid and ptr, never on own valid.
- At most one handshake per cycle. After a grant to requester k when both were valid, ptr <= !k. Grant with only one valid leaves ptr unchanged.
- Conjugate: imag' = -imag (WIDTH-bit two's complement, wraps: -2^(WIDTH-1) maps to itself); real unchanged. conj=0 passes B unmodified. A is never modified.
- Issue register: on handshake, m_valid<=1, m_a<=A, m_b<=B'; otherwise m_valid<=0, m_a/m_b hold last value.
- Tag pipeline: LAT stages of {valid, id}, entered from the issue register in step with m_valid. When the last stage is valid, m_p is registered into r<id>_data and r<id>_valid pulses for one cycle; other requester's valid stays 0, its data holds.
- Results return in issue order; per-requester order preserved.
- idle = !m_valid & no tag stage valid.
- Reset (any cycle, including with beats in flight): ptr<=0, m_valid<=0, m_a/m_b<=0, all tags cleared, r0/r1_valid<=0, r0/r1_data<=0, idle=1 the cycle after. Products already in the multiplier are discarded; ready low while rst high.

## Timing

- Handshake on edge t -> m_valid high in cycle t+1 -> m_p sampled at t+1+LAT -> r<id>_valid high in cycle t+2+LAT. Total latency LAT+2 clocks.
- Throughput: one beat per cycle aggregate; a sole requester sustains 1 beat/cycle; both continuously valid alternate 0,1,0,1 (50% each).
- Simultaneous result strobe and new handshake in the same cycle are independent; no bubbles.
- No combinational path from m_p to outputs; from s*_valid only to the other s*_ready.

## Test plan

- Single beat, LAT=4, WIDTH=32: s0 a={1,2}, b={5,3}, conj=1 at t=0 -> m_b={-5,3} in cycle 1; model product returned; r0_valid only in cycle 6, r1_valid stays 0.
- Both valid every cycle from reset for 8 cycles -> grants 0,1,0,1,0,1,0,1; r0/r1_valid alternate starting cycle 6; tags match model.
- s1 alone valid 10 consecutive cycles, conj=0 -> s1_ready high all 10, m_b equals s1_b, 10 consecutive r1_valid pulses in order.
- Wrap: b imag=0x80000000, conj=1 -> m_b imag 0x80000000; b imag=0x00000001 -> 0xFFFFFFFF.
- Priority retention: s0 only valid for 3 beats, then both -> first contested grant goes to s0 (ptr still 0), next to s1.
- Reset with 3 beats in flight -> no r*_valid for LAT+2 cycles after, outputs zero, idle=1 cycle after reset; first post-reset beat returns with correct tag and latency.

Source files
------------

// File: rtl/cmul_arbiter_if.sv
// cmul_arbiter_if: requester, multiplier and result signals of the complex-multiplier arbiter.
// slave is the arbiter side; master is the requesters plus the multiplier around it.
interface cmul_arbiter_if #(
   parameter int WIDTH = 32
);
   logic               s0_valid, s0_ready, s0_conj;
   logic               s1_valid, s1_ready, s1_conj;
   logic [2*WIDTH-1:0] s0_a, s0_b, s1_a, s1_b;
   logic               m_valid;
   logic [2*WIDTH-1:0] m_a, m_b;
   logic [4*WIDTH-1:0] m_p;
   logic               r0_valid, r1_valid;
   logic [4*WIDTH-1:0] r0_data, r1_data;
   logic               idle;
   modport slave (
      input  s0_valid, s0_conj, s0_a, s0_b, s1_valid, s1_conj, s1_a, s1_b, m_p,
      output s0_ready, s1_ready, m_valid, m_a, m_b, r0_valid, r1_valid, r0_data, r1_data, idle
   );
   modport master (
      output s0_valid, s0_conj, s0_a, s0_b, s1_valid, s1_conj, s1_a, s1_b, m_p,
      input  s0_ready, s1_ready, m_valid, m_a, m_b, r0_valid, r1_valid, r0_data, r1_data, idle
   );
endinterface

// File: rtl/cmul_arbiter.sv
// cmul_arbiter: round-robin share of one pipelined complex multiplier between two requesters.
// A LAT-deep tag pipeline follows each issued beat so its product returns to the issuer.
module cmul_arbiter #(
   parameter int WIDTH = 32,
   parameter int LAT   = 4
) (
   input  logic          clk,
   input  logic          rst,
   cmul_arbiter_if.slave io_bus
);
   logic               r_ptr, r_m_valid, r_m_id;
   logic [2*WIDTH-1:0] r_m_a, r_m_b;
   logic [LAT-1:0]     r_tag_v, r_tag_id;
   logic               r_r0_valid, r_r1_valid;
   logic [4*WIDTH-1:0] r_r0_data, r_r1_data;
   logic               w_s0_ready, w_s1_ready, w_hs0, w_hs1, w_hs, w_conj, w_ret0, w_ret1;
   logic [2*WIDTH-1:0] w_a, w_b, w_b_conj;
   logic [WIDTH-1:0]   w_imag;

   always_comb begin
      w_s0_ready = !rst && (!r_ptr || !io_bus.s1_valid);
      w_s1_ready = !rst && (r_ptr || !io_bus.s0_valid);
      w_hs0      = io_bus.s0_valid && w_s0_ready;
      w_hs1      = io_bus.s1_valid && w_s1_ready;
      w_hs       = w_hs0 || w_hs1;
      w_a        = w_hs1 ? io_bus.s1_a : io_bus.s0_a;
      w_b        = w_hs1 ? io_bus.s1_b : io_bus.s0_b;
      w_conj     = w_hs1 ? io_bus.s1_conj : io_bus.s0_conj;
      w_imag     = w_b[2*WIDTH-1:WIDTH];
      // negation wraps, so the most negative imag maps to itself
      w_b_conj   = {w_conj ? {WIDTH{1'b0}} - w_imag : w_imag, w_b[WIDTH-1:0]};
      w_ret0     = r_tag_v[LAT-1] && !r_tag_id[LAT-1];
      w_ret1     = r_tag_v[LAT-1] && r_tag_id[LAT-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_id     <= 1'b0;
         r_m_a      <= '0;
         r_m_b      <= '0;
         r_tag_v    <= '0;
         r_tag_id   <= '0;
         r_r0_valid <= 1'b0;
         r_r1_valid <= 1'b0;
         r_r0_data  <= '0;
         r_r1_data  <= '0;
      end else begin
         if (io_bus.s0_valid && io_bus.s1_valid && w_hs) r_ptr <= w_hs0;
         r_m_valid <= w_hs;
         if (w_hs) begin
            r_m_id <= w_hs1;
            r_m_a  <= w_a;
            r_m_b  <= w_b_conj;
         end
         r_tag_v    <= LAT'({r_tag_v, r_m_valid});
         r_tag_id   <= LAT'({r_tag_id, r_m_id});
         r_r0_valid <= w_ret0;
         r_r1_valid <= w_ret1;
         if (w_ret0) r_r0_data <= io_bus.m_p;
         if (w_ret1) r_r1_data <= io_bus.m_p;
      end
   end

   assign io_bus.s0_ready = w_s0_ready;
   assign io_bus.s1_ready = w_s1_ready;
   assign io_bus.m_valid  = r_m_valid;
   assign io_bus.m_a      = r_m_a;
   assign io_bus.m_b      = r_m_b;
   assign io_bus.r0_valid = r_r0_valid;
   assign io_bus.r1_valid = r_r1_valid;
   assign io_bus.r0_data  = r_r0_data;
   assign io_bus.r1_data  = r_r1_data;
   assign io_bus.idle     = !r_m_valid && !(|r_tag_v);
endmodule

// File: tb/tb_cmul_arbiter.sv
// tb_cmul_arbiter: directed and random stimulus against a scoreboard of expected results,
// with a behavioural LAT-cycle complex multiplier driving m_p.
module tb_cmul_arbiter;
   localparam int WIDTH = 32, LAT = 4, PW = 4 * WIDTH;

   typedef struct {
      int            due;
      logic          id;
      logic [PW-1:0] p;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cmul_arbiter_if #(.WIDTH(WIDTH)) bus ();
   cmul_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (.clk(clk), .rst(rst), .io_bus(bus));

   int            errors = 0, checks = 0, cyc = 0;
   ent_t          q[$];
   logic          ptr = 1'b0, exp_mv = 1'b0;
   logic [63:0]   exp_ma = '0, exp_mb = '0;
   logic [PW-1:0] exp_r0d = '0, exp_r1d = '0;
   logic [PW-1:0] mul_pipe [LAT];

   function automatic logic [PW-1:0] cmul(input logic [63:0] a, input logic [63:0] b);
      longint ar, ai, br, bi;
      ar = longint'($signed(a[31:0]));
      ai = longint'($signed(a[63:32]));
      br = longint'($signed(b[31:0]));
      bi = longint'($signed(b[63:32]));
      return {64'(ar * bi + ai * br), 64'(ar * br - ai * bi)};
   endfunction

   function automatic logic [63:0] conj(input logic [63:0] b);
      logic [31:0] im;
      im = b[63:32];
      return {32'(0 - int'(im)), b[31:0]};
   endfunction

   function automatic logic [63:0] rnd64();
      logic [31:0] re, im;
      re = $urandom;
      im = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      return {im, re};
   endfunction

   // the multiplier: valid product LAT cycles after m_valid, junk otherwise
   assign bus.m_p = mul_pipe[LAT-1];
   always @(posedge clk) begin
      mul_pipe[0] <= bus.m_valid ? cmul(bus.m_a, bus.m_b) : {$urandom, $urandom, $urandom, $urandom};
      for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
   end

   task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic r, input logic v0, input logic v1, input logic c0, input logic c1,
                       input logic [63:0] a0, input logic [63:0] b0,
                       input logic [63:0] a1, input logic [63:0] b1);
      logic          e0v, e1v, g0, g1, c;
      logic [63:0]   a, b;
      ent_t          e;
      @(negedge clk);
      cyc++;
      e0v = 1'b0;
      e1v = 1'b0;
      if (q.size() != 0 && q[0].due == cyc) begin
         e = q.pop_front();
         if (e.id) begin e1v = 1'b1; exp_r1d = e.p; end
         else begin e0v = 1'b1; exp_r0d = e.p; end
      end
      chk("r0_valid", PW'(bus.r0_valid), PW'(e0v));
      chk("r1_valid", PW'(bus.r1_valid), PW'(e1v));
      chk("r0_data", bus.r0_data, exp_r0d);
      chk("r1_data", bus.r1_data, exp_r1d);
      chk("m_valid", PW'(bus.m_valid), PW'(exp_mv));
      chk("m_a", PW'(bus.m_a), PW'(exp_ma));
      chk("m_b", PW'(bus.m_b), PW'(exp_mb));
      chk("idle", PW'(bus.idle), PW'(q.size() == 0 && !exp_mv));
      rst = r;
      bus.s0_valid = v0; bus.s1_valid = v1; bus.s0_conj = c0; bus.s1_conj = c1;
      bus.s0_a = a0; bus.s0_b = b0; bus.s1_a = a1; bus.s1_b = b1;
      #1;
      g0 = !r && v0 && (!v1 || !ptr);
      g1 = !r && v1 && (!v0 || ptr);
      chk("s0_ready", PW'(bus.s0_ready), PW'(!r && (!ptr || !v1)));
      chk("s1_ready", PW'(bus.s1_ready), PW'(!r && (ptr || !v0)));
      exp_mv = g0 || g1;
      if (g0 || g1) begin
         a = g1 ? a1 : a0;
         b = g1 ? b1 : b0;
         c = g1 ? c1 : c0;
         exp_ma = a;
         exp_mb = c ? conj(b) : b;
         q.push_back('{due: cyc + LAT + 2, id: g1, p: cmul(a, exp_mb)});
         if (v0 && v1) ptr = !g1;
      end
      if (r) begin
         q.delete();
         ptr = 1'b0; exp_mv = 1'b0; exp_ma = '0; exp_mb = '0; exp_r0d = '0; exp_r1d = '0;
      end
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, '0, '0, '0);
   endtask

   initial begin
      bus.s0_valid = 0; bus.s1_valid = 0; bus.s0_conj = 0; bus.s1_conj = 0;
      bus.s0_a = '0; bus.s0_b = '0; bus.s1_a = '0; bus.s1_b = '0;
      step(1, 0, 0, 0, 0, '0, '0, '0, '0);
      idle_steps(2);
      // single conjugated beat from s0
      step(0, 1, 0, 1, 0, {32'd1, 32'd2}, {32'd5, 32'd3}, '0, '0);
      idle_steps(1);
      chk("single m_b", PW'(bus.m_b), PW'({32'hFFFF_FFFB, 32'd3}));
      idle_steps(LAT + 2);
      // both valid continuously: strict alternation
      for (int i = 0; i < 8; i++) step(0, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                                       rnd64(), rnd64(), rnd64(), rnd64());
      idle_steps(LAT + 2);
      // s1 alone, back to back
      for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, '0, '0, rnd64(), rnd64());
      idle_steps(LAT + 2);
      // wrap of the most negative imag, and imag 1
      step(0, 1, 0, 1, 0, rnd64(), {32'h8000_0000, 32'h1234_5678}, '0, '0);
      step(0, 1, 0, 1, 0, rnd64(), {32'h0000_0001, 32'h0000_0009}, '0, '0);
      chk("wrap min", PW'(bus.m_b), PW'({32'h8000_0000, 32'h1234_5678}));
      idle_steps(1);
      chk("wrap one", PW'(bus.m_b), PW'({32'hFFFF_FFFF, 32'h0000_0009}));
      idle_steps(LAT + 2);
      // priority retention after uncontested grants
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, rnd64(), rnd64(), '0, '0);
      step(0, 1, 1, 0, 0, rnd64(), rnd64(), rnd64(), rnd64());
      chk("contested s0 first", PW'(bus.s0_ready), PW'(1'b1));
      step(0, 1, 1, 0, 0, rnd64(), rnd64(), rnd64(), rnd64());
      chk("contested s1 next", PW'(bus.s1_ready), PW'(1'b1));
      idle_steps(LAT + 2);
      // reset with beats in flight, then a fresh beat
      for (int i = 0; i < 3; i++) step(0, i[0], !i[0], 1, 0, rnd64(), rnd64(), rnd64(), rnd64());
      step(1, 1, 1, 0, 0, rnd64(), rnd64(), rnd64(), rnd64());
      idle_steps(LAT + 3);
      step(0, 0, 1, 1, 1, '0, '0, rnd64(), rnd64());
      idle_steps(LAT + 3);
      // random traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 1), $urandom_range(0, 1), rnd64(), rnd64(), rnd64(), rnd64());
      idle_steps(LAT + 3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
